// File: rtl/spi_slave_rx_pkg.sv
// -----------------------------------------------------------------------------
// spi_slave_rx_pkg
// Definitions shared by the SPI responder, the baud SCK generator and the
// future SPI master: SPI mode encodings, byte width, the default dummy byte
// and the responder state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package spi_slave_rx_pkg;

  localparam int SPI_BYTE_W = 8;

  typedef logic [SPI_BYTE_W-1:0] spi_byte_t;

  // CPOL: level of SCK while the bus is idle.
  localparam bit SPI_CPOL_IDLE_LOW = 1'b0;

  // CPHA: which SCK edge the receiver samples on.
  localparam bit SPI_CPHA_LEAD  = 1'b0;
  localparam bit SPI_CPHA_TRAIL = 1'b1;

  // Byte shifted out when the transmit holding register is empty.
  localparam spi_byte_t SPI_DUMMY_DEFAULT = 8'h00;

  typedef enum logic {
    SPI_IDLE   = 1'b0,
    SPI_ACTIVE = 1'b1
  } spi_state_t;

endpackage

// File: rtl/spi_slave_rx_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_slave_rx_sync_edge
// STAGES-deep synchronizer for one asynchronous input, followed by an edge
// detector that compares the last synchronized sample with the one before it.
// A pin change shows up on rise/fall after STAGES clk edges, so logic that
// registers on those pulses reacts STAGES+1 clk after the pin.
//
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-high reset
//   din   in   asynchronous input pin
//   level out  synchronized level
//   rise  out  one-cycle pulse on a synchronized 0->1 transition
//   fall  out  one-cycle pulse on a synchronized 1->0 transition
// -----------------------------------------------------------------------------
module spi_slave_rx_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // The chain and the history flop reset to the pin's idle level so that
  // leaving reset never produces a spurious edge pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_rx.sv
// -----------------------------------------------------------------------------
// spi_slave_rx
// SPI responder. SCK, CS_N and MOSI are oversampled in the clk domain; bytes
// are shifted in on sample edges and shifted out on shift edges. Each received
// byte is presented on rx_data with a one-cycle rx_valid pulse. Transmit bytes
// enter through a one-entry holding register with a valid/ready handshake;
// when the register is empty at a load point, DUMMY is sent and underrun
// pulses for one clk.
//
// Build option: define SPI_SLAVE_LSB_FIRST_EN to shift both directions
// LSB-first. Default build is MSB-first.
//
// Parameters: CPOL (SCK idle level), CPHA (0 = sample on leading edge,
//   1 = sample on trailing edge), DUMMY (underrun byte), SYNC_STAGES (2..3).
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   sck, cs_n, mosi SPI pins from the master (asynchronous to clk)
//   miso, miso_oe   SPI data out and its pad enable (high while selected)
//   tx_data/valid   byte offered for transmission
//   tx_ready        holding register empty
//   rx_data/valid   last received byte and its one-cycle update pulse
//   underrun        one-cycle pulse when DUMMY was loaded
//   busy            synchronized cs_n asserted
// -----------------------------------------------------------------------------
module spi_slave_rx
  import spi_slave_rx_pkg::*;
#(
  parameter bit        CPOL        = SPI_CPOL_IDLE_LOW,
  parameter bit        CPHA        = SPI_CPHA_LEAD,
  parameter spi_byte_t DUMMY       = SPI_DUMMY_DEFAULT,
  parameter int        SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       underrun,
  output logic       busy
);

  logic sck_level, sck_rise, sck_fall;
  logic cs_level, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi_s;

  spi_state_t state;
  spi_byte_t  tx_sr;
  spi_byte_t  hold_q;
  logic       hold_full;
  logic [6:0] rx_sr;
  logic [2:0] bit_cnt;

  logic lead_edge, trail_edge, sample_edge, shift_edge, load_now;
  spi_byte_t rx_byte, tx_shifted;
  logic [6:0] rx_next;

  spi_slave_rx_sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (CPOL)
  ) u_sck_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (sck),
    .level (sck_level),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  spi_slave_rx_sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_cs_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (cs_n),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // MOSI only needs the same synchronizer depth as SCK so that the data
  // sample lines up with the detected clock edge; no edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_sync <= '0;
    end else begin
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Classify SCK edges: an edge that leaves the idle level is the leading
  // edge, one that returns to it is the trailing edge. A load point is the
  // shift edge that starts a byte (counter at 0); with CPHA=0 the first byte
  // of a frame is instead loaded when chip select falls.
  always_comb begin
    lead_edge   = (sck_rise | sck_fall) & (sck_level != CPOL);
    trail_edge  = (sck_rise | sck_fall) & (sck_level == CPOL);
    sample_edge = (CPHA == SPI_CPHA_TRAIL) ? trail_edge : lead_edge;
    shift_edge  = (CPHA == SPI_CPHA_TRAIL) ? lead_edge : trail_edge;
    load_now    = ((state == SPI_ACTIVE) && !cs_rise && shift_edge && (bit_cnt == 3'd0)) ||
                  ((state == SPI_IDLE) && cs_fall && (CPHA == SPI_CPHA_LEAD));
  end

  // Bit ordering. rx_sr keeps only the 7 bits already received; the 8th bit
  // is taken straight from the synchronizer when the byte completes.
`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign rx_byte    = {mosi_s, rx_sr};
  assign rx_next    = rx_byte[7:1];
  assign tx_shifted = {1'b0, tx_sr[7:1]};
  assign miso       = (state == SPI_ACTIVE) ? tx_sr[0] : 1'b0;
`else
  assign rx_byte    = {rx_sr, mosi_s};
  assign rx_next    = rx_byte[6:0];
  assign tx_shifted = {tx_sr[6:0], 1'b0};
  assign miso       = (state == SPI_ACTIVE) ? tx_sr[7] : 1'b0;
`endif

  assign miso_oe  = (state == SPI_ACTIVE);
  assign tx_ready = ~hold_full;
  assign busy     = ~cs_level;

  // Responder state machine, holding register and shift registers. A write
  // and a consume of the holding register are mutually exclusive because a
  // write needs it empty and a consume from it needs it full. Chip select
  // rising abandons any partial byte but leaves the holding register intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SPI_IDLE;
      tx_sr     <= '0;
      hold_q    <= '0;
      hold_full <= 1'b0;
      rx_sr     <= '0;
      bit_cnt   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      underrun <= 1'b0;

      if (tx_valid && !hold_full) begin
        hold_q    <= tx_data;
        hold_full <= 1'b1;
      end

      if (load_now) begin
        if (hold_full) begin
          tx_sr     <= hold_q;
          hold_full <= 1'b0;
        end else begin
          tx_sr    <= DUMMY;
          underrun <= 1'b1;
        end
      end

      case (state)
        SPI_IDLE: begin
          bit_cnt <= '0;
          if (cs_fall) begin
            state <= SPI_ACTIVE;
          end
        end
        SPI_ACTIVE: begin
          if (cs_rise) begin
            state   <= SPI_IDLE;
            bit_cnt <= '0;
          end else begin
            if (sample_edge) begin
              rx_sr   <= rx_next;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data  <= rx_byte;
                rx_valid <= 1'b1;
              end
            end
            if (shift_edge && (bit_cnt != 3'd0)) begin
              tx_sr <= tx_shifted;
            end
          end
        end
        default: state <= SPI_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_rx
// Drives four responders (SPI modes 0..3) from one bit-banged master. The
// master clock is shared; CPOL=1 instances see it inverted, and CPHA=0/1
// instances get their own MOSI line timed for their sample edge. A small
// model tracks each instance's holding register and predicts the byte sent
// at every load point, the number of underruns and the received bytes.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_slave_rx;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       sck_base, cs_n, mosi0, mosi1;
  logic [3:0] tx_valid;
  logic [7:0] tx_data [4];
  logic [3:0] miso_w, miso_oe_w, tx_ready_w, rx_valid_w, underrun_w, busy_w;
  logic [7:0] rx_data_w [4];

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] dummyOf(input int m);
    case (m)
      1:       return 8'hFF;
      2:       return 8'h5A;
      3:       return 8'hC3;
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit cpolOf(input int m);
    return (m & 2) != 0;
  endfunction

  function automatic bit cphaOf(input int m);
    return (m & 1) != 0;
  endfunction

  for (genvar m = 0; m < 4; m++) begin : g_dut
    logic sck_pin, mosi_pin;
    assign sck_pin  = sck_base ^ cpolOf(m);
    assign mosi_pin = cphaOf(m) ? mosi1 : mosi0;
    spi_slave_rx #(
      .CPOL        (cpolOf(m)),
      .CPHA        (cphaOf(m)),
      .DUMMY       (dummyOf(m)),
      .SYNC_STAGES (SYNC)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .sck      (sck_pin),
      .cs_n     (cs_n),
      .mosi     (mosi_pin),
      .miso     (miso_w[m]),
      .miso_oe  (miso_oe_w[m]),
      .tx_data  (tx_data[m]),
      .tx_valid (tx_valid[m]),
      .tx_ready (tx_ready_w[m]),
      .rx_data  (rx_data_w[m]),
      .rx_valid (rx_valid_w[m]),
      .underrun (underrun_w[m]),
      .busy     (busy_w[m])
    );
  end

  // Output monitor: logs received bytes, counts underrun cycles and counts
  // rx_valid pulses that last longer than one clk.
  int         rxCnt [4]  = '{default: 0};
  int         urunCnt [4] = '{default: 0};
  int         rxLong [4] = '{default: 0};
  logic [7:0] rxLog [4][64];
  logic [3:0] rxPrev = '0;

  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (rx_valid_w[m]) begin
        rxLog[m][rxCnt[m] % 64] = rx_data_w[m];
        rxCnt[m] = rxCnt[m] + 1;
        if (rxPrev[m]) rxLong[m] = rxLong[m] + 1;
      end
      if (underrun_w[m]) urunCnt[m] = urunCnt[m] + 1;
    end
    rxPrev = rx_valid_w;
  end

  // Reference model state.
  bit         modelFull [4];
  logic [7:0] modelHold [4];
  int         expUrun [4];
  int         loadIdx [4];
  logic [7:0] expTx [4][4];
  logic [7:0] capTx [4][4];

  // Frame plan, filled in before each call of applyStimulus.
  int         frN, halfT, abortKind;
  logic [7:0] frBytes [3];
  logic [3:0] preMask;
  logic [7:0] preVal [4];
  logic [3:0] midMask [3];
  logic [7:0] midVal [3][4];
  logic [7:0] wrVal [4];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int bitPos(input int i);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    return i;
`else
    return 7 - i;
`endif
  endfunction

  function automatic logic bitOf(input logic [7:0] b, input int i);
    return b[bitPos(i)];
  endfunction

  task automatic checkResetState(input string tag);
    for (int m = 0; m < 4; m++) begin
      checkOutput($sformatf("%s m%0d", tag, m),
                  {18'd0, miso_w[m], miso_oe_w[m], tx_ready_w[m], rx_valid_w[m],
                   underrun_w[m], busy_w[m], rx_data_w[m]},
                  32'h0000_0800);
    end
  endtask

  // A load point: the held byte if there is one, otherwise the dummy byte
  // together with one underrun.
  task automatic modelLoad(input int m);
    logic [7:0] v;
    if (modelFull[m]) begin
      v = modelHold[m];
      modelFull[m] = 1'b0;
    end else begin
      v = dummyOf(m);
      expUrun[m]++;
    end
    if (loadIdx[m] < 4) expTx[m][loadIdx[m]] = v;
    loadIdx[m]++;
  endtask

  // One-clk write opportunity; writes only where the plan asks and the
  // model says the holding register is free.
  task automatic writeSlot(input logic [3:0] mask);
    for (int m = 0; m < 4; m++) begin
      checkOutput($sformatf("tx_ready m%0d", m), {31'd0, tx_ready_w[m]}, {31'd0, !modelFull[m]});
      if (mask[m] && !modelFull[m]) begin
        tx_valid[m]  = 1'b1;
        tx_data[m]   = wrVal[m];
        modelFull[m] = 1'b1;
        modelHold[m] = wrVal[m];
      end
    end
    waitClk(1);
    tx_valid = '0;
  endtask

  task automatic planFrame(input int n, input int ht, input int ab);
    frN       = n;
    halfT     = ht;
    abortKind = ab;
    preMask   = '0;
    for (int k = 0; k < 3; k++) begin
      midMask[k] = '0;
      frBytes[k] = 8'h00;
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    #1;
    checkResetState("mid-frame reset");
    sck_base = 1'b0;
    cs_n     = 1'b1;
    mosi0    = 1'b0;
    mosi1    = 1'b0;
    tx_valid = '0;
    waitClk(2);
    rst = 1'b0;
    for (int m = 0; m < 4; m++) modelFull[m] = 1'b0;
    waitClk(3);
  endtask

  task automatic applyStimulus();
    int rx0 [4];
    int ur0 [4];
    int rl0 [4];
    int nExp;
    bit stop;
    stop = 1'b0;
    for (int m = 0; m < 4; m++) begin
      rx0[m]     = rxCnt[m];
      ur0[m]     = urunCnt[m];
      rl0[m]     = rxLong[m];
      expUrun[m] = 0;
      loadIdx[m] = 0;
      wrVal[m]   = preVal[m];
    end
    writeSlot(preMask);
    waitClk(3);
    cs_n = 1'b0;
    for (int m = 0; m < 4; m++) if (!cphaOf(m)) modelLoad(m);
    waitClk(halfT);
    for (int k = 0; k < frN; k++) begin
      for (int i = 0; i < 8; i++) begin
        if (abortKind == 1 && k == 0 && i == 5) begin
          stop = 1'b1;
          break;
        end
        if (abortKind == 2 && k == 0 && i == 3) begin
          doReset();
          return;
        end
        mosi0 = bitOf(frBytes[k], i);
        if (i == 3) begin
          for (int m = 0; m < 4; m++) begin
            checkOutput($sformatf("busy m%0d", m), {31'd0, busy_w[m]}, 32'd1);
            checkOutput($sformatf("miso_oe m%0d", m), {31'd0, miso_oe_w[m]}, 32'd1);
            wrVal[m] = midVal[k][m];
          end
          writeSlot(midMask[k]);
          waitClk(halfT - 1);
        end else begin
          waitClk(halfT);
        end
        for (int m = 0; m < 4; m++) begin
          if (!cphaOf(m)) capTx[m][k][bitPos(i)] = miso_w[m];
          else if (i == 0) modelLoad(m);
        end
        sck_base = 1'b1;
        mosi1    = bitOf(frBytes[k], i);
        waitClk(halfT);
        for (int m = 0; m < 4; m++) begin
          if (cphaOf(m)) capTx[m][k][bitPos(i)] = miso_w[m];
        end
        sck_base = 1'b0;
        for (int m = 0; m < 4; m++) begin
          if (!cphaOf(m) && i == 7) modelLoad(m);
        end
      end
      if (stop) break;
    end
    waitClk(halfT);
    cs_n = 1'b1;
    waitClk(SYNC + 2);
    for (int m = 0; m < 4; m++) begin
      checkOutput($sformatf("miso_oe off m%0d", m), {31'd0, miso_oe_w[m]}, 32'd0);
      checkOutput($sformatf("busy off m%0d", m), {31'd0, busy_w[m]}, 32'd0);
    end
    waitClk(4);
    nExp = (abortKind == 1) ? 0 : frN;
    for (int m = 0; m < 4; m++) begin
      checkOutput($sformatf("rx count m%0d", m), rxCnt[m] - rx0[m], nExp);
      checkOutput($sformatf("rx_valid width m%0d", m), rxLong[m] - rl0[m], 32'd0);
      checkOutput($sformatf("underrun count m%0d", m), urunCnt[m] - ur0[m], expUrun[m]);
      for (int k = 0; k < nExp; k++) begin
        checkOutput($sformatf("rx byte%0d m%0d", k, m), {24'd0, rxLog[m][(rx0[m] + k) % 64]}, {24'd0, frBytes[k]});
        checkOutput($sformatf("miso byte%0d m%0d", k, m), {24'd0, capTx[m][k]}, {24'd0, expTx[m][k]});
      end
      if (nExp > 0) checkOutput($sformatf("rx_data m%0d", m), {24'd0, rx_data_w[m]}, {24'd0, frBytes[nExp-1]});
    end
  endtask

  initial begin
    rst      = 1'b1;
    sck_base = 1'b0;
    cs_n     = 1'b1;
    mosi0    = 1'b0;
    mosi1    = 1'b0;
    tx_valid = '0;
    for (int m = 0; m < 4; m++) begin
      tx_data[m]   = 8'h00;
      modelFull[m] = 1'b0;
      modelHold[m] = 8'h00;
    end
    waitClk(3);
    checkResetState("reset state");
    rst = 1'b0;
    waitClk(3);

    // Single byte A5 with 3C pre-loaded.
    planFrame(1, 5, 0);
    frBytes[0] = 8'hA5;
    preMask    = 4'hF;
    for (int m = 0; m < 4; m++) preVal[m] = 8'h3C;
    applyStimulus();

    // Back-to-back 12, 34 with C3 pre-loaded and 5A refilled mid-byte.
    planFrame(2, 6, 0);
    frBytes[0] = 8'h12;
    frBytes[1] = 8'h34;
    preMask    = 4'hF;
    midMask[0] = 4'hF;
    for (int m = 0; m < 4; m++) begin
      preVal[m]    = 8'hC3;
      midVal[0][m] = 8'h5A;
    end
    applyStimulus();

    // No transmit data at all: dummy bytes and underruns.
    planFrame(1, 5, 0);
    frBytes[0] = 8'h00;
    applyStimulus();

    // Chip select raised after 5 bits, then a clean frame.
    planFrame(1, 5, 1);
    frBytes[0] = 8'hF0;
    applyStimulus();
    planFrame(1, 5, 0);
    frBytes[0] = 8'h81;
    applyStimulus();

    // Reset in the middle of a frame, then a clean frame.
    planFrame(1, 5, 2);
    frBytes[0] = 8'h66;
    applyStimulus();
    planFrame(1, 5, 0);
    frBytes[0] = 8'h66;
    applyStimulus();

    // Bit-order check: 01 received, 80 transmitted.
    planFrame(1, 5, 0);
    frBytes[0] = 8'h01;
    preMask    = 4'hF;
    for (int m = 0; m < 4; m++) preVal[m] = 8'h80;
    applyStimulus();

    // Random frames.
    for (int t = 0; t < 12; t++) begin
      planFrame($urandom_range(3, 1), $urandom_range(7, 5), ($urandom_range(7, 0) == 0) ? 1 : 0);
      preMask = 4'($urandom_range(15, 0));
      for (int k = 0; k < 3; k++) begin
        frBytes[k] = 8'($urandom);
        midMask[k] = 4'($urandom_range(15, 0));
        for (int m = 0; m < 4; m++) midVal[k][m] = 8'($urandom);
      end
      for (int m = 0; m < 4; m++) preVal[m] = 8'($urandom);
      applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- SPI responder (slave) for the opposite end of the link clocked by the team's `baud` SCK generator.
- Oversamples SCK, CS_N and MOSI in the system clock domain and shifts bytes in and out.
- Delivers each received byte as a one-cycle pulse and takes transmit bytes through a valid/ready holding register.
- Sits between the external SPI pins and the APB register file.

Parameters:
- CPOL, 0: SCK idle level.
- CPHA, 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- DUMMY, 8'h00: byte shifted out when no transmit data is held.
- SYNC_STAGES, 2: synchronizer depth for sck/cs_n/mosi (legal range 2..3).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- sck  in  1  SPI clock from master, asynchronous to clk
- cs_n  in  1  chip select, active low, asynchronous
- mosi  in  1  master-out data, asynchronous
- miso  out  1  slave-out data
- miso_oe  out  1  output enable for miso pad, high while selected
- tx_data  in  8  byte to transmit
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  holding register empty
- rx_data  out  8  last complete received byte
- rx_valid  out  1  one-cycle pulse, rx_data updated
- underrun  out  1  one-cycle pulse, DUMMY was loaded
- busy  out  1  cs_n (synchronized) asserted

Behaviour:
- Reset values: miso=0, miso_oe=0, tx_ready=1, rx_data=8'h00, rx_valid=0, underrun=0, busy=0, bit counter=0, holding register empty.
- Async rst clears all state immediately, including mid-byte.
- Timing: inputs pass through SYNC_STAGES flops. Edge detect compares the last synced sample with the previous one.
  - Pin-to-detect latency is SYNC_STAGES+1 clk.
  - SCK high and low times must each be ≥4 clk (baud psc≥1 satisfies this).
- Edge naming:
  - Leading edge = idle→active SCK transition (rising when CPOL=0).
  - Sample edge = leading if CPHA=0, else trailing. Shift edge = the other edge.
- States:
  - IDLE: cs_n high; miso_oe=0; counter held at 0.
  - IDLE→ACTIVE: on synced cs_n falling. If CPHA=0, load the shift register in the same cycle.
  - ACTIVE: miso = tx shift register MSB; miso_oe=1.
    - On each sample edge: rx shift register <= {rx_sr[6:0], mosi}; counter++.
    - On each shift edge: tx_sr <<= 1, except at the load points below.
  - ACTIVE→IDLE: on synced cs_n rising, from any bit position.
- Byte completion: on the 8th sample edge (counter wraps 7→0), in the cycle after the edge:
  - rx_data <= assembled byte;
  - rx_valid=1 for exactly 1 clk.
- Load points (tx_sr <= holding reg, or DUMMY if empty):
  - CPHA=0: cs_n fall, and the first shift edge after a completed byte.
  - CPHA=1: first shift edge (leading) of each byte.
  - On a load from the holding register: holding register empties and tx_ready rises the next clk.
  - On a load with the register empty: DUMMY is sent and underrun pulses 1 clk.
- Holding register handshake:
  - Write when tx_valid && tx_ready; tx_ready falls the next clk.
  - A write and a consume in the same clk cannot collide, because tx_ready=0 while full.
- cs_n rising mid-byte:
  - partial byte discarded, no rx_valid;
  - counter reset;
  - holding register contents preserved;
  - miso_oe=0 the next clk.
- SCK edges while IDLE are ignored. MOSI is not sampled when cs_n is high.

Optional Feature:
- Macro SPI_SLAVE_LSB_FIRST_EN.
  - Defined: both shift registers are LSB-first (rx_sr <= {mosi, rx_sr[7:1]}, miso = tx_sr[0]).
  - Undefined: MSB-first as above.
- Handshake and timing are identical in both builds.

Decomposition:
- Shared header spi_defs.vh: CPOL/CPHA mode encodings, SPI_BYTE_W=8, default DUMMY value, state encodings IDLE/ACTIVE. The header is shared with the `baud` block and the future SPI master.
- One sub-module, spi_sync_edge: SYNC_STAGES-deep synchronizer plus rise/fall pulse outputs, instantiated for sck and cs_n (mosi uses the synchronizer only).

Test Plan:
- Mode 0, psc=4, master sends 8'hA5 after tx_data=8'h3C was written → rx_data=8'hA5 with one rx_valid pulse; master reads 8'h3C on miso; tx_ready rises after the load at cs_n fall.
- Mode 3, two back-to-back bytes 8'h12, 8'h34 with holding register refilled between them (8'hC3, 8'h5A) → two rx_valid pulses in order; miso carries 8'hC3 then 8'h5A; underrun never asserts.
- No tx write, mode 1 with DUMMY=8'hFF, master sends 8'h00 → miso reads 8'hFF; underrun pulses once at the first shift edge; rx_data=8'h00.
- cs_n raised after 5 bits of 8'hF0 → no rx_valid; miso_oe=0 within SYNC_STAGES+2 clk. The next full frame 8'h81 receives correctly.
- rst asserted mid-frame (bit 3) → all outputs return to reset values immediately; a subsequent frame 8'h66 completes normally.
- With SPI_SLAVE_LSB_FIRST_EN defined: master sends LSB-first 8'h01 → rx_data=8'h01; tx 8'h80 appears on miso LSB-first.
